if_pc_fetch: RTL and testbench

IF_PC_FETCH -- requirements
Module: if_pc_fetch

---
 rtl/if_pc_fetch.sv | 79 +++++++
 tb/tb_if_pc_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_fetch.sv
// if_pc_fetch: PC register and instruction-fetch handshake with exception redirect; define FETCH_ADEL_EN to enable fetch address-error detection
module if_pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NextPC,
  input  logic        Stall,
  input  logic        ExcReq,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_IF,
  output logic        Valid_IF,
  output logic        FetchStall,
  output logic        AdEL_IF
);
  localparam logic [1:0] FETCH = 2'd0, DRAIN = 2'd1, ADEL = 2'd2;
`ifdef FETCH_ADEL_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redir;
  logic        r_pend;
  logic        w_bad;
  logic        w_adel;
  logic        w_req;
  logic        w_done;
  logic        w_valid;
  // decode the fetch status; a bad PC in FETCH behaves as ADEL immediately so no request escapes
  always_comb begin
    w_bad   = ADEL_EN && (r_pc[1:0] != 2'b00 || r_pc < IM_BASE || r_pc > IM_END);
    w_adel  = reset && (r_state == ADEL || (r_state == FETCH && w_bad));
    w_req   = reset && !w_adel && (r_state == FETCH || r_state == DRAIN);
    w_done  = w_req && im_ready;
    w_valid = ((r_state == FETCH && w_done) || w_adel) && !ExcReq;
  end
  assign im_req     = w_req;
  assign im_addr    = r_pc;
  assign PC_IF      = r_pc;
  assign Valid_IF   = w_valid;
  assign Instr_IF   = w_valid ? im_rdata : 32'h0;
  assign FetchStall = w_req && !im_ready;
  assign AdEL_IF    = w_adel;
  // advance the PC, park on address errors, and drain an outstanding fetch before redirecting
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_redir <= 32'h0;
      r_pend  <= 1'b0;
    end else if (w_adel) begin
      r_state <= ExcReq ? FETCH : ADEL;
      if (ExcReq) r_pc <= EXC_VECTOR;
    end else if (r_state == DRAIN) begin
      if (im_ready) begin
        r_pc    <= r_pend ? r_redir : r_pc;
        r_pend  <= 1'b0;
        r_state <= FETCH;
      end
    end else if (r_state != FETCH) begin
      r_state <= FETCH;
    end else if (im_ready) begin
      if (ExcReq) r_pc <= EXC_VECTOR;
      else if (!Stall) r_pc <= NextPC;
    end else if (ExcReq) begin
      r_redir <= EXC_VECTOR;
      r_pend  <= 1'b1;
      r_state <= DRAIN;
    end
endmodule

// File: tb/tb_if_pc_fetch.sv
// tb_if_pc_fetch: directed and random-ready stimulus checked against a behavioural fetch model
module tb_if_pc_fetch;
`ifdef FETCH_ADEL_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NextPC;
  logic        Stall;
  logic        ExcReq;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] PC_IF;
  logic [31:0] Instr_IF;
  logic        Valid_IF;
  logic        FetchStall;
  logic        AdEL_IF;
  logic        auto_np;
  logic [31:0] np_val;
  int n_cmp = 0;
  int n_bad = 0;

  if_pc_fetch dut (
    .clk(clk), .reset(reset), .NextPC(NextPC), .Stall(Stall), .ExcReq(ExcReq),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .PC_IF(PC_IF), .Instr_IF(Instr_IF), .Valid_IF(Valid_IF), .FetchStall(FetchStall),
    .AdEL_IF(AdEL_IF)
  );

  always #5 clk = ~clk;
  always_comb NextPC = auto_np ? PC_IF + 32'd4 : np_val;
  always_comb im_rdata = {16'hC0DE, im_addr[15:0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return ADEL_ON && (a[1:0] != 2'b00 || a < 32'h0000_3000 || a > 32'h0000_6FFC);
  endfunction

  // behavioural model: current PC plus a queue holding the redirect target of a fetch being drained
  logic [31:0] m_pc;
  logic [31:0] m_drain[$];
  bit          m_known = 1'b0;
  bit          e_adel, e_req, e_valid, e_drn;

  always @(negedge clk) begin
    e_drn   = m_drain.size() != 0;
    e_adel  = reset && m_known && !e_drn && bad_addr(m_pc);
    e_req   = reset && !e_adel;
    e_valid = reset && !ExcReq && ((e_req && im_ready && !e_drn) || e_adel);
    chk("m_im_req", 32'(im_req), 32'(e_req));
    chk("m_valid", 32'(Valid_IF), 32'(e_valid));
    chk("m_instr", Instr_IF, e_valid ? im_rdata : 32'h0);
    chk("m_fstall", 32'(FetchStall), 32'(e_req && !im_ready));
    chk("m_adel", 32'(AdEL_IF), 32'(e_adel));
    if (m_known) chk("m_pc", PC_IF, m_pc);
    if (m_known && e_req) chk("m_im_addr", im_addr, m_pc);
    if (!reset) begin
      m_pc = 32'h0000_3000;
      m_drain.delete();
      m_known = 1'b1;
    end else if (e_adel) begin
      if (ExcReq) m_pc = 32'h0000_4180;
    end else if (e_drn) begin
      if (im_ready) m_pc = m_drain.pop_front();
    end else if (im_ready) begin
      m_pc = ExcReq ? 32'h0000_4180 : (Stall ? m_pc : NextPC);
    end else if (ExcReq) begin
      m_drain.push_back(32'h0000_4180);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; Stall = 1'b0; ExcReq = 1'b0; im_ready = 1'b1; auto_np = 1'b0; np_val = 32'h0000_3004;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; ExcReq = 1'b0; im_ready = 1'b1; auto_np = 1'b0; np_val = 32'h0000_3004;
    tick();
    tick();
    chk("rst_pc", PC_IF, 32'h0000_3000);
    chk("rst_req", 32'(im_req), 32'd0);
    chk("rst_valid", 32'(Valid_IF), 32'd0);
    chk("rst_instr", Instr_IF, 32'h0);
    // sequential fetch with memory always ready
    reset = 1'b1; auto_np = 1'b1;
    #1;
    chk("seq_a0", im_addr, 32'h0000_3000);
    chk("seq_v0", 32'(Valid_IF), 32'd1);
    tick();
    chk("seq_a1", im_addr, 32'h0000_3004);
    tick();
    chk("seq_a2", im_addr, 32'h0000_3008);
    chk("seq_i2", Instr_IF, 32'hC0DE_3008);
    tick();
    // memory wait states at 0x3004
    do_reset();
    tick();
    im_ready = 1'b0; np_val = 32'h0000_3010;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_fs", 32'(FetchStall), 32'd1);
      chk("wait_addr", im_addr, 32'h0000_3004);
      chk("wait_valid", 32'(Valid_IF), 32'd0);
      tick();
    end
    im_ready = 1'b1;
    #1;
    chk("wait_done_v", 32'(Valid_IF), 32'd1);
    chk("wait_done_i", Instr_IF, 32'hC0DE_3004);
    tick();
    chk("wait_next", PC_IF, 32'h0000_3010);
    // pipeline stall holds the PC and re-requests it
    do_reset();
    np_val = 32'h0000_3008;
    tick();
    Stall = 1'b1; np_val = 32'h0000_300C;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("stall_req", 32'(im_req), 32'd1);
      chk("stall_addr", im_addr, 32'h0000_3008);
      tick();
    end
    Stall = 1'b0;
    #1;
    chk("stall_hold", PC_IF, 32'h0000_3008);
    tick();
    chk("stall_adv", PC_IF, 32'h0000_300C);
    // exception while a fetch is outstanding: drain then redirect
    do_reset();
    np_val = 32'h0000_3020;
    tick();
    im_ready = 1'b0; ExcReq = 1'b1;
    #1;
    chk("exc_fs", 32'(FetchStall), 32'd1);
    tick();
    Stall = 1'b1; np_val = 32'h0000_3040;
    #1;
    chk("drain_addr", im_addr, 32'h0000_3020);
    chk("drain_req", 32'(im_req), 32'd1);
    tick();
    ExcReq = 1'b0; im_ready = 1'b1;
    #1;
    chk("drain_valid", 32'(Valid_IF), 32'd0);
    chk("drain_instr", Instr_IF, 32'h0);
    tick();
    Stall = 1'b0;
    #1;
    chk("exc_vec", im_addr, 32'h0000_4180);
    // misaligned fetch address
    do_reset();
    np_val = 32'h0000_3002;
    tick();
    #1;
`ifdef FETCH_ADEL_EN
    chk("adel_req", 32'(im_req), 32'd0);
    chk("adel_flag", 32'(AdEL_IF), 32'd1);
    chk("adel_valid", 32'(Valid_IF), 32'd1);
    chk("adel_pc", PC_IF, 32'h0000_3002);
    tick();
    chk("adel_hold", PC_IF, 32'h0000_3002);
    ExcReq = 1'b1;
    tick();
    ExcReq = 1'b0;
    #1;
    chk("adel_exc", im_addr, 32'h0000_4180);
    chk("adel_exc_req", 32'(im_req), 32'd1);
`else
    chk("noadel_req", 32'(im_req), 32'd1);
    chk("noadel_addr", im_addr, 32'h0000_3002);
    chk("noadel_flag", 32'(AdEL_IF), 32'd0);
`endif
    // reset in the middle of a drain abandons it
    do_reset();
    np_val = 32'h0000_3020;
    tick();
    im_ready = 1'b0; ExcReq = 1'b1;
    tick();
    ExcReq = 1'b0; reset = 1'b0;
    #1;
    chk("rdrain_req", 32'(im_req), 32'd0);
    tick();
    chk("rdrain_pc", PC_IF, 32'h0000_3000);
    chk("rdrain_req2", 32'(im_req), 32'd0);
    tick();
    reset = 1'b1; im_ready = 1'b1; np_val = 32'h0000_3004;
    #1;
    chk("rdrain_addr", im_addr, 32'h0000_3000);
    tick();
    chk("rdrain_next", PC_IF, 32'h0000_3004);
    // random handshake, stall, exception and target mix, checked by the model
    for (int i = 0; i < 200; i++) begin
      im_ready = 1'($urandom_range(0, 2) != 0);
      Stall = 1'($urandom_range(0, 3) == 0);
      ExcReq = 1'($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: np_val = 32'hFFFF_FFFC;
        1: np_val = 32'h0000_3001;
        2: np_val = 32'h0000_6FFC;
        default: np_val = 32'h0000_3000 + {$urandom_range(0, 255), 2'b00};
      endcase
      auto_np = 1'($urandom_range(0, 1));
      reset = 1'($urandom_range(0, 49) != 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
